amber48_mem_stage: RTL and testbench
====================================

# amber48_mem_stage

Memory/writeback stage of the amber48 pipeline and the consuming end of the `amber48_execute_out_s` interface. It accepts one executed instruction at a time over a valid/ready handshake and performs the data-memory access for loads and stores. It then issues the register-file write as an `amber48_regfile_req_s` and reports data faults and forwarded traps.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 64: maximum cycles a load waits for a response; only used with `AMBER48_MEM_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock, all logic on the rising edge
- `rst_n`  in  1  reset, **synchronous, active-low**
- `in_valid_i`  in  1  execute result valid
- `in_ready_o`  out  1  stage can accept
- `in_i`  in  `amber48_execute_out_s`  executed instruction
- `dmem_req_valid_o`  out  1  data-memory request
- `dmem_req_ready_i`  in  1  memory accepts request
- `dmem_req_we_o`  out  1  1 = store, 0 = load
- `dmem_req_addr_o`  out  `$clog2(DMEM_DEPTH)`  BAU word index
- `dmem_req_wdata_o`  out  `XLEN`  store data
- `dmem_rsp_valid_i`  in  1  load data valid
- `dmem_rsp_data_i`  in  `XLEN`  load data
- `dmem_rsp_err_i`  in  1  load error, qualified by `dmem_rsp_valid_i`
- `rf_req_o`  out  `amber48_regfile_req_s`  write port. `addr_a` and `addr_b` are always 0.
- `trap_o`  out  1  one-cycle trap pulse
- `trap_cause_o`  out  `amber48_trap_e`  cause, valid with `trap_o`
- `busy_o`  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, REQ, RSP, DONE.
- **Acceptance.** In IDLE, `in_ready_o` = 1, and a transfer occurs when `in_valid_i && in_i.valid`. If `in_valid_i` is high with `in_i.valid` = 0, the item is consumed and has no effect.
- **Address check.** A memory op uses byte address `in_i.result`.
  - Data fault if `result[2:0]` ≠ 0 (misaligned to `BAU_BYTES`).
  - Data fault if `result[XLEN-1:3]` ≥ `DMEM_DEPTH`.
  - Otherwise the word index is `result[10:3]`.
- **Classification on acceptance,** evaluated in priority order:
  1. `in_i.trap`: go to DONE, forward `in_i.trap_cause`, no write, no access.
  2. `load && store`: go to DONE with TRAP_ILLEGAL.
  3. Memory op with address fault: go to DONE with TRAP_DATA_FAULT.
  4. Load or store: go to REQ.
  5. Otherwise: go to DONE. The write is `writeback_en` with `wd = result`.
- **REQ.** `dmem_req_valid_o` = 1, with addr/we/wdata held stable until `dmem_req_ready_i`.
  - Store: on handshake, go to IDLE. No register write.
  - Load: on handshake, go to RSP.
- **RSP.** Wait for `dmem_rsp_valid_i`.
  - `dmem_rsp_err_i` = 1: go to DONE with TRAP_DATA_FAULT and no write.
  - Otherwise: go to DONE with `wd = dmem_rsp_data_i`, write enabled if `writeback_en`.
- **DONE.** Lasts exactly one cycle.
  - `rf_req_o.valid`/`we` = 1 when a write is pending and `rd` ≠ `REG_ZERO`.
  - `trap_o` = 1 if a trap is pending.
  - Next state is IDLE.
- A write to `REG_ZERO` is always suppressed (`we` = 0, valid = 0).

## Timing
- **Reset.** State IDLE. Every output is 0 (`rf_req_o` = '0, `trap_cause_o` = TRAP_NONE), except `in_ready_o`, which is 1 from the first cycle after reset.
- `in_ready_o` is combinational from state only: it is 1 only in IDLE, so there is no back-to-back acceptance.
- **ALU op.** Accepted in cycle N; the write is visible in N+1. Throughput is 1 instruction per 2 cycles.
- **Load.** Accepted N; `dmem_req_valid_o` from N+1; response in cycle R; write in R+1.
- **Store.** Accepted N; request from N+1; back in IDLE the cycle after the handshake.
- `dmem_rsp_valid_i` outside RSP is ignored.
- A response arriving in the same cycle as the request handshake is not legal from memory. The stage ignores it and keeps waiting in RSP.
- `rst_n` low mid-transaction: on the next edge the FSM returns to IDLE, `dmem_req_valid_o` drops, and any pending write or trap is discarded.

## Configuration
- `AMBER48_MEM_TIMEOUT_EN` defined:
  - RSP carries a counter, cleared on RSP entry.
  - If `TIMEOUT_CYCLES` cycles elapse without `dmem_rsp_valid_i`, go to DONE with TRAP_DATA_FAULT and no write.
  - A later stray response is ignored.
- Undefined: no counter; RSP waits indefinitely.

## Structure
- Add the following to the shared amber48 package:
  - an `amber48_mem_state_e` enum (IDLE/REQ/RSP/DONE);
  - a `DMEM_ADDR_WIDTH = $clog2(DMEM_DEPTH)` constant;
  - a `BAU_SHIFT = $clog2(BAU_BYTES)` constant.
- One sub-module, `amber48_dmem_addr_check`: a combinational alignment/range check that returns the word index and a fault flag.

## Test plan
- **ALU op.** ADD result 0x00000000002A, `rd` = 3, `writeback_en` = 1 → next cycle `rf_req_o` = {valid 1, `addr_w` 3, we 1, wd 0x2A}; `in_ready_o` = 0 for that cycle.
- **Load with stalls.** Load at result 0x40 with `dmem_req_ready_i` held low 3 cycles → `dmem_req_addr_o` = 8 stable. Then respond with 0xABCDEF012345 two cycles later → `rd` written 0xABCDEF012345 the cycle after the response.
- **Store.** Result 0x18, `store_data` 0x111 → request {we 1, addr 3, wdata 0x111}; no `rf_req_o` write; `in_ready_o` = 1 the cycle after the handshake.
- **Faults.**
  - Load at 0x44 → `trap_o` pulse with TRAP_DATA_FAULT and no dmem request.
  - Store at 0x800 → same.
  - Load with `dmem_rsp_err_i` = 1 → TRAP_DATA_FAULT and no write.
- **Forwarded trap.** `in_i.trap` = 1 with TRAP_ILLEGAL → `trap_cause_o` = TRAP_ILLEGAL.
- **Zero register and reset.** Write with `rd` = 0 → `rf_req_o.we` = 0. `rst_n` low while in REQ → `dmem_req_valid_o` = 0 after the edge. With `AMBER48_MEM_TIMEOUT_EN` and no response → trap exactly `TIMEOUT_CYCLES` cycles after RSP entry.

Source files
------------

// File: rtl/amber48_pkg.sv
// Shared amber48 types and constants: execute/regfile interfaces, trap causes,
// memory-stage state encoding and data-memory geometry.
package amber48_pkg;

  localparam int unsigned XLEN            = 48;
  localparam int unsigned DMEM_DEPTH      = 256;
  localparam int unsigned BAU_BYTES       = 8;
  localparam int unsigned NUM_REGS        = 16;
  localparam int unsigned REG_ADDR_WIDTH  = $clog2(NUM_REGS);
  localparam int unsigned DMEM_ADDR_WIDTH = $clog2(DMEM_DEPTH);
  localparam int unsigned BAU_SHIFT       = $clog2(BAU_BYTES);

  typedef logic [REG_ADDR_WIDTH-1:0] amber48_reg_t;

  localparam amber48_reg_t REG_ZERO = '0;

  typedef enum logic [1:0] {
    TRAP_NONE,
    TRAP_ILLEGAL,
    TRAP_DATA_FAULT,
    TRAP_ECALL
  } amber48_trap_e;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StRsp,
    StDone
  } amber48_mem_state_e;

  typedef struct packed {
    logic          valid;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] store_data;
    amber48_reg_t  rd;
    logic          writeback_en;
    logic          load;
    logic          store;
    logic          trap;
    amber48_trap_e trap_cause;
  } amber48_execute_out_s;

  typedef struct packed {
    logic            valid;
    amber48_reg_t    addr_a;
    amber48_reg_t    addr_b;
    amber48_reg_t    addr_w;
    logic            we;
    logic [XLEN-1:0] wd;
  } amber48_regfile_req_s;

  // Register-file write request; writes to the zero register collapse to no request.
  function automatic amber48_regfile_req_s rf_write(input amber48_reg_t    rd,
                                                    input logic            en,
                                                    input logic [XLEN-1:0] wd);
    amber48_regfile_req_s req;
    req = '0;
    if (en && (rd != REG_ZERO)) begin
      req.valid  = 1'b1;
      req.addr_w = rd;
      req.we     = 1'b1;
      req.wd     = wd;
    end
    return req;
  endfunction

endpackage

// File: rtl/amber48_dmem_addr_check.sv
// Combinational alignment and range check of a byte address against the data memory.
module amber48_dmem_addr_check
  import amber48_pkg::*;
(
  input  logic [XLEN-1:0]            addr,
  output logic [DMEM_ADDR_WIDTH-1:0] word,
  output logic                       fault
);

  localparam int unsigned HiLsb = BAU_SHIFT + DMEM_ADDR_WIDTH;

  // DMEM_DEPTH is a power of two, so out-of-range means any bit above the word index.
  always_comb begin
    word  = addr[BAU_SHIFT +: DMEM_ADDR_WIDTH];
    fault = (addr[BAU_SHIFT-1:0] != '0) || (addr[XLEN-1:HiLsb] != '0);
  end

endmodule

// File: rtl/amber48_mem_stage.sv
// amber48 memory/writeback stage: data-memory access, register write and trap reporting.
// Optional response timeout in RSP enabled by defining AMBER48_MEM_TIMEOUT_EN.
module amber48_mem_stage
  import amber48_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  amber48_execute_out_s       in_i,
  output logic                       dmem_req_valid_o,
  input  logic                       dmem_req_ready_i,
  output logic                       dmem_req_we_o,
  output logic [DMEM_ADDR_WIDTH-1:0] dmem_req_addr_o,
  output logic [XLEN-1:0]            dmem_req_wdata_o,
  input  logic                       dmem_rsp_valid_i,
  input  logic [XLEN-1:0]            dmem_rsp_data_i,
  input  logic                       dmem_rsp_err_i,
  output amber48_regfile_req_s       rf_req_o,
  output logic                       trap_o,
  output amber48_trap_e              trap_cause_o,
  output logic                       busy_o
);

  amber48_mem_state_e         state_q;
  amber48_reg_t               rd_q;
  logic                       wb_q;
  logic [DMEM_ADDR_WIDTH-1:0] word;
  logic                       addr_fault;
  logic                       mem_op;

`ifdef AMBER48_MEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT_CYCLES - 1);
  logic [CntW-1:0] tmo_cnt_q;
`endif

  amber48_dmem_addr_check u_addr_check (
    .addr  (in_i.result),
    .word  (word),
    .fault (addr_fault)
  );

  assign mem_op     = in_i.load || in_i.store;
  assign in_ready_o = (state_q == StIdle);
  assign busy_o     = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      rd_q             <= REG_ZERO;
      wb_q             <= 1'b0;
      dmem_req_valid_o <= 1'b0;
      dmem_req_we_o    <= 1'b0;
      dmem_req_addr_o  <= '0;
      dmem_req_wdata_o <= '0;
      rf_req_o         <= '0;
      trap_o           <= 1'b0;
      trap_cause_o     <= TRAP_NONE;
`ifdef AMBER48_MEM_TIMEOUT_EN
      tmo_cnt_q        <= '0;
`endif
    end else begin
      // Write and trap are single-cycle pulses presented during DONE.
      rf_req_o     <= '0;
      trap_o       <= 1'b0;
      trap_cause_o <= TRAP_NONE;
      case (state_q)
        StIdle: begin
          if (in_valid_i && in_i.valid) begin
            rd_q <= in_i.rd;
            wb_q <= in_i.writeback_en;
            if (in_i.trap) begin
              state_q      <= StDone;
              trap_o       <= 1'b1;
              trap_cause_o <= in_i.trap_cause;
            end else if (in_i.load && in_i.store) begin
              state_q      <= StDone;
              trap_o       <= 1'b1;
              trap_cause_o <= TRAP_ILLEGAL;
            end else if (mem_op && addr_fault) begin
              state_q      <= StDone;
              trap_o       <= 1'b1;
              trap_cause_o <= TRAP_DATA_FAULT;
            end else if (mem_op) begin
              state_q          <= StReq;
              dmem_req_valid_o <= 1'b1;
              dmem_req_we_o    <= in_i.store;
              dmem_req_addr_o  <= word;
              dmem_req_wdata_o <= in_i.store ? in_i.store_data : '0;
            end else begin
              state_q  <= StDone;
              rf_req_o <= rf_write(in_i.rd, in_i.writeback_en, in_i.result);
            end
          end
        end
        StReq: begin
          if (dmem_req_ready_i) begin
            dmem_req_valid_o <= 1'b0;
            state_q          <= dmem_req_we_o ? StIdle : StRsp;
`ifdef AMBER48_MEM_TIMEOUT_EN
            tmo_cnt_q        <= '0;
`endif
          end
        end
        StRsp: begin
          if (dmem_rsp_valid_i) begin
            state_q <= StDone;
            if (dmem_rsp_err_i) begin
              trap_o       <= 1'b1;
              trap_cause_o <= TRAP_DATA_FAULT;
            end else begin
              rf_req_o <= rf_write(rd_q, wb_q, dmem_rsp_data_i);
            end
          end
`ifdef AMBER48_MEM_TIMEOUT_EN
          else if (tmo_cnt_q == TmoLast) begin
            state_q      <= StDone;
            trap_o       <= 1'b1;
            trap_cause_o <= TRAP_DATA_FAULT;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_amber48_mem_stage.sv
// Self-checking bench for amber48_mem_stage: directed vector table, random transactions
// against a behavioural model, and hand sequences for reset and response-wait corners.
module tb_amber48_mem_stage;
  import amber48_pkg::*;

  localparam int unsigned TMO    = 20;
  localparam int          BUDGET = 200;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  amber48_execute_out_s  in_data;
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [7:0]            req_addr;
  logic [47:0]           req_wdata;
  logic                  rsp_valid;
  logic [47:0]           rsp_data;
  logic                  rsp_err;
  amber48_regfile_req_s  rf_req;
  logic                  trap;
  amber48_trap_e         trap_cause;
  logic                  busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  amber48_mem_stage #(
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid_i       (in_valid),
    .in_ready_o       (in_ready),
    .in_i             (in_data),
    .dmem_req_valid_o (req_valid),
    .dmem_req_ready_i (req_ready),
    .dmem_req_we_o    (req_we),
    .dmem_req_addr_o  (req_addr),
    .dmem_req_wdata_o (req_wdata),
    .dmem_rsp_valid_i (rsp_valid),
    .dmem_rsp_data_i  (rsp_data),
    .dmem_rsp_err_i   (rsp_err),
    .rf_req_o         (rf_req),
    .trap_o           (trap),
    .trap_cause_o     (trap_cause),
    .busy_o           (busy)
  );

  typedef struct {
    bit            req;
    logic          we;
    logic [7:0]    addr;
    logic [47:0]   wdata;
    bit            wr;
    logic [3:0]    waddr;
    logic [47:0]   wd;
    bit            trap;
    amber48_trap_e cause;
  } exp_t;

  typedef struct {
    bit            done;
    bit            rdy0;
    int            req_seen;
    int            req_first;
    bit            req_unstable;
    logic          we;
    logic [7:0]    addr;
    logic [47:0]   wdata;
    int            wr_seen;
    bit            rd_ports_nz;
    logic [3:0]    waddr;
    logic [47:0]   wd;
    int            wr_cyc;
    int            trap_seen;
    amber48_trap_e cause;
    int            trap_cyc;
    int            rsp_cyc;
    int            hs_cyc;
    int            idle_cyc;
  } obs_t;

  typedef struct {
    amber48_execute_out_s ins;
    int                   stalls;
    int                   dly;
    logic [47:0]          rdata;
    bit                   rerr;
    bit                   stray;
    exp_t                 e;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  function automatic amber48_execute_out_s mk(input bit v, input logic [47:0] res,
                                              input logic [47:0] sd, input logic [3:0] rd,
                                              input bit wb, input bit ld, input bit st,
                                              input bit tr, input amber48_trap_e tc);
    amber48_execute_out_s x;
    x.valid = v; x.result = res; x.store_data = sd; x.rd = rd; x.writeback_en = wb;
    x.load = ld; x.store = st; x.trap = tr; x.trap_cause = tc;
    return x;
  endfunction

  function automatic exp_t mkexp(input bit req, input logic we, input logic [7:0] addr,
                                 input logic [47:0] wdata, input bit wr, input logic [3:0] waddr,
                                 input logic [47:0] wd, input bit tr, input amber48_trap_e c);
    exp_t e;
    e.req = req; e.we = we; e.addr = addr; e.wdata = wdata; e.wr = wr; e.waddr = waddr;
    e.wd = wd; e.trap = tr; e.cause = c;
    return e;
  endfunction

  // Behavioural outcome of one instruction, straight from the stage's rules.
  function automatic exp_t model(input amber48_execute_out_s x, input logic [47:0] rdata,
                                 input bit rerr);
    exp_t        e;
    logic [47:0] a;
    bit          bad;
    e = mkexp(0, 0, 0, 0, 0, 0, 0, 0, TRAP_NONE);
    a = x.result;
    bad = ((a % 48'd8) != 0) || ((a / 48'd8) >= 48'd256);
    if (!x.valid) return e;
    if (x.trap) begin
      e.trap = 1; e.cause = x.trap_cause;
    end else if (x.load && x.store) begin
      e.trap = 1; e.cause = TRAP_ILLEGAL;
    end else if ((x.load || x.store) && bad) begin
      e.trap = 1; e.cause = TRAP_DATA_FAULT;
    end else if (x.store) begin
      e.req = 1; e.we = 1; e.addr = 8'(a / 48'd8); e.wdata = x.store_data;
    end else if (x.load) begin
      e.req = 1; e.we = 0; e.addr = 8'(a / 48'd8);
      if (rerr) begin
        e.trap = 1; e.cause = TRAP_DATA_FAULT;
      end else if (x.writeback_en && x.rd != 0) begin
        e.wr = 1; e.waddr = x.rd; e.wd = rdata;
      end
    end else if (x.writeback_en && x.rd != 0) begin
      e.wr = 1; e.waddr = x.rd; e.wd = x.result;
    end
    return e;
  endfunction

  function automatic obs_t obs_clear();
    obs_t o;
    o.done = 0; o.rdy0 = 0; o.req_seen = 0; o.req_first = -1; o.req_unstable = 0;
    o.we = 0; o.addr = 0; o.wdata = 0; o.wr_seen = 0; o.rd_ports_nz = 0; o.waddr = 0;
    o.wd = 0; o.wr_cyc = -1; o.trap_seen = 0; o.cause = TRAP_NONE; o.trap_cyc = -1;
    o.rsp_cyc = -1; o.hs_cyc = -1; o.idle_cyc = -1;
    return o;
  endfunction

  // Present one instruction and act as the data memory until the stage returns to idle.
  task automatic run_txn(input amber48_execute_out_s x, input int stalls, input int dly,
                         input logic [47:0] rdata, input bit rerr, input bit stray,
                         output obs_t o);
    int stall_cnt, rsp_cnt, w;
    bit hs_next, in_rsp, rsp_sent;
    o = obs_clear();
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    in_valid = 1'b1;
    in_data  = x;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
    stall_cnt = 0; rsp_cnt = 0; hs_next = 0; in_rsp = 0; rsp_sent = 0;
    o.rdy0 = in_ready;
    for (int c = 0; c < BUDGET; c++) begin
      if (rf_req.valid || rf_req.we) begin
        o.wr_seen++; o.waddr = rf_req.addr_w; o.wd = rf_req.wd; o.wr_cyc = c;
      end
      if (rf_req.addr_a != 0 || rf_req.addr_b != 0) o.rd_ports_nz = 1;
      if (trap) begin
        o.trap_seen++; o.cause = trap_cause; o.trap_cyc = c;
      end
      if (req_valid) begin
        if (o.req_seen == 0) begin
          o.req_first = c; o.we = req_we; o.addr = req_addr; o.wdata = req_wdata;
        end else if (req_we !== o.we || req_addr !== o.addr || req_wdata !== o.wdata) begin
          o.req_unstable = 1;
        end
        o.req_seen++;
      end
      if (!busy) begin
        o.done = 1; o.idle_cyc = c;
        break;
      end
      if (hs_next) begin
        in_rsp = 1; hs_next = 0;
      end
      req_ready = 0; rsp_valid = 0; rsp_data = '0; rsp_err = 0;
      if (req_valid) begin
        if (stall_cnt == stalls) begin
          req_ready = 1; o.hs_cyc = c; hs_next = x.load;
          if (stray) begin
            rsp_valid = 1; rsp_data = 48'hBAD0_BAD0_BAD0;
          end
        end else begin
          stall_cnt++;
        end
      end else if (in_rsp && !rsp_sent) begin
        if (rsp_cnt == dly) begin
          rsp_valid = 1; rsp_data = rdata; rsp_err = rerr; rsp_sent = 1; o.rsp_cyc = c;
        end else begin
          rsp_cnt++;
        end
      end
      @(negedge clk);
    end
    req_ready = 0; rsp_valid = 0; rsp_data = '0; rsp_err = 0;
  endtask

  task automatic check_txn(input string nm, input amber48_execute_out_s x, input int stalls,
                           input exp_t e, input obs_t o);
    chk({nm, "_done"}, 64'(o.done), 1);
    chk({nm, "_ready_after_accept"}, 64'(o.rdy0), 64'(!x.valid));
    chk({nm, "_req_seen"}, 64'(o.req_seen != 0), 64'(e.req));
    if (e.req) begin
      chk({nm, "_req_first_cyc"}, 64'(o.req_first), 0);
      chk({nm, "_req_cycles"}, 64'(o.req_seen), 64'(stalls + 1));
      chk({nm, "_req_stable"}, 64'(o.req_unstable), 0);
      chk({nm, "_req_we"}, 64'(o.we), 64'(e.we));
      chk({nm, "_req_addr"}, 64'(o.addr), 64'(e.addr));
      if (e.we) begin
        chk({nm, "_req_wdata"}, 64'(o.wdata), 64'(e.wdata));
        chk({nm, "_store_idle_cyc"}, 64'(o.idle_cyc), 64'(o.hs_cyc + 1));
      end
    end
    chk({nm, "_wr_count"}, 64'(o.wr_seen), 64'(e.wr));
    chk({nm, "_rd_ports_zero"}, 64'(o.rd_ports_nz), 0);
    if (e.wr) begin
      chk({nm, "_wr_addr"}, 64'(o.waddr), 64'(e.waddr));
      chk({nm, "_wr_data"}, 64'(o.wd), 64'(e.wd));
      chk({nm, "_wr_cyc"}, 64'(o.wr_cyc), x.load ? 64'(o.rsp_cyc + 1) : 64'd0);
    end
    chk({nm, "_trap_count"}, 64'(o.trap_seen), 64'(e.trap));
    if (e.trap) begin
      chk({nm, "_trap_cause"}, 64'(o.cause), 64'(e.cause));
      chk({nm, "_trap_cyc"}, 64'(o.trap_cyc), e.req ? 64'(o.rsp_cyc + 1) : 64'd0);
    end
  endtask

  vec_t vecs[15];
  obs_t o;

  initial begin
    rst_n = 0; in_valid = 0; in_data = '0;
    req_ready = 0; rsp_valid = 0; rsp_data = '0; rsp_err = 0;

    vecs[0]  = '{mk(1, 48'h2A, 0, 3, 1, 0, 0, 0, TRAP_NONE), 0, 0, 0, 0, 0,
                 mkexp(0, 0, 0, 0, 1, 3, 48'h2A, 0, TRAP_NONE)};
    vecs[1]  = '{mk(1, 48'h40, 0, 5, 1, 1, 0, 0, TRAP_NONE), 3, 2, 48'hABCDEF012345, 0, 0,
                 mkexp(1, 0, 8, 0, 1, 5, 48'hABCDEF012345, 0, TRAP_NONE)};
    vecs[2]  = '{mk(1, 48'h18, 48'h111, 7, 1, 0, 1, 0, TRAP_NONE), 1, 0, 0, 0, 0,
                 mkexp(1, 1, 3, 48'h111, 0, 0, 0, 0, TRAP_NONE)};
    vecs[3]  = '{mk(1, 48'h44, 0, 2, 1, 1, 0, 0, TRAP_NONE), 0, 0, 0, 0, 0,
                 mkexp(0, 0, 0, 0, 0, 0, 0, 1, TRAP_DATA_FAULT)};
    vecs[4]  = '{mk(1, 48'h800, 48'h5, 2, 0, 0, 1, 0, TRAP_NONE), 0, 0, 0, 0, 0,
                 mkexp(0, 0, 0, 0, 0, 0, 0, 1, TRAP_DATA_FAULT)};
    vecs[5]  = '{mk(1, 48'h10, 0, 4, 1, 1, 0, 0, TRAP_NONE), 0, 1, 48'h99, 1, 0,
                 mkexp(1, 0, 2, 0, 0, 0, 0, 1, TRAP_DATA_FAULT)};
    vecs[6]  = '{mk(1, 48'h8, 0, 4, 1, 1, 0, 1, TRAP_ILLEGAL), 0, 0, 0, 0, 0,
                 mkexp(0, 0, 0, 0, 0, 0, 0, 1, TRAP_ILLEGAL)};
    vecs[7]  = '{mk(1, 48'h77, 0, 0, 1, 0, 0, 0, TRAP_NONE), 0, 0, 0, 0, 0,
                 mkexp(0, 0, 0, 0, 0, 0, 0, 0, TRAP_NONE)};
    vecs[8]  = '{mk(1, 48'h8, 48'h1, 6, 1, 1, 1, 0, TRAP_NONE), 0, 0, 0, 0, 0,
                 mkexp(0, 0, 0, 0, 0, 0, 0, 1, TRAP_ILLEGAL)};
    vecs[9]  = '{mk(1, 48'h7F8, 0, 9, 1, 1, 0, 0, TRAP_NONE), 0, 1, 48'h123, 0, 1,
                 mkexp(1, 0, 255, 0, 1, 9, 48'h123, 0, TRAP_NONE)};
    vecs[10] = '{mk(0, 48'h8, 0, 9, 1, 1, 0, 0, TRAP_NONE), 0, 0, 0, 0, 0,
                 mkexp(0, 0, 0, 0, 0, 0, 0, 0, TRAP_NONE)};
    vecs[11] = '{mk(1, 48'h55, 0, 8, 0, 0, 0, 0, TRAP_NONE), 0, 0, 0, 0, 0,
                 mkexp(0, 0, 0, 0, 0, 0, 0, 0, TRAP_NONE)};
    vecs[12] = '{mk(1, 48'hFFFFFFFFFFF1, 0, 15, 1, 0, 0, 0, TRAP_NONE), 0, 0, 0, 0, 0,
                 mkexp(0, 0, 0, 0, 1, 15, 48'hFFFFFFFFFFF1, 0, TRAP_NONE)};
    vecs[13] = '{mk(1, 48'h20, 0, 0, 1, 1, 0, 0, TRAP_NONE), 2, 0, 48'h777, 0, 0,
                 mkexp(1, 0, 4, 0, 0, 0, 0, 0, TRAP_NONE)};
    vecs[14] = '{mk(1, 48'h7FF, 48'h3, 1, 0, 0, 1, 0, TRAP_NONE), 0, 0, 0, 0, 0,
                 mkexp(0, 0, 0, 0, 0, 0, 0, 1, TRAP_DATA_FAULT)};

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_req_valid", 64'(req_valid), 0);
    chk("rst_req_fields", {15'd0, req_we, req_addr, req_wdata}, 0);
    chk("rst_rf_req", 64'(rf_req), 0);
    chk("rst_trap", 64'(trap), 0);
    chk("rst_trap_cause", 64'(trap_cause), 64'(TRAP_NONE));
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 1);

    for (int i = 0; i < 15; i++) begin
      run_txn(vecs[i].ins, vecs[i].stalls, vecs[i].dly, vecs[i].rdata, vecs[i].rerr,
              vecs[i].stray, o);
      check_txn($sformatf("vec%0d", i), vecs[i].ins, vecs[i].stalls, vecs[i].e, o);
    end

    for (int i = 0; i < 40; i++) begin
      amber48_execute_out_s x;
      logic [47:0]          res, rdata;
      int                   k, stalls, dly;
      bit                   rerr, stray;
      amber48_trap_e        tc;
      case ($urandom_range(0, 3))
        0, 1:    res = 48'($urandom_range(0, 255)) * 48'd8;
        2: begin
          res = 48'($urandom_range(0, 2047));
          if (res % 8 == 0) res = res + 48'd1;
        end
        default: res = {16'($urandom), 32'($urandom)};
      endcase
      k = $urandom_range(0, 9);
      tc = amber48_trap_e'(2'($urandom_range(1, 3)));
      x = mk(1, res, {16'($urandom), 32'($urandom)}, 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), (k >= 3 && k <= 5) || k == 8, k == 6 || k == 7 || k == 8,
             k == 9, tc);
      stalls = $urandom_range(0, 3);
      dly    = $urandom_range(0, 3);
      rdata  = {16'($urandom), 32'($urandom)};
      rerr   = ($urandom_range(0, 7) == 0);
      stray  = ($urandom_range(0, 3) == 0);
      run_txn(x, stalls, dly, rdata, rerr, stray, o);
      check_txn($sformatf("rnd%0d", i), x, stalls, model(x, rdata, rerr), o);
    end

    // Reset while a load request is stalled
    in_valid = 1; in_data = mk(1, 48'h20, 0, 3, 1, 1, 0, 0, TRAP_NONE);
    @(negedge clk);
    in_valid = 0; in_data = '0;
    @(negedge clk);
    chk("midreq_req_valid_before", 64'(req_valid), 1);
    rst_n = 0;
    @(negedge clk);
    chk("midreq_req_valid_after", 64'(req_valid), 0);
    chk("midreq_busy_after", 64'(busy), 0);
    chk("midreq_in_ready_after", 64'(in_ready), 1);
    rst_n = 1;
    @(negedge clk);
    chk("midreq_no_trap", 64'(trap), 0);
    chk("midreq_no_write", 64'(rf_req), 0);

    // Load whose response never arrives
    run_txn(mk(1, 48'h30, 0, 2, 1, 1, 0, 0, TRAP_NONE), 0, 1000000, 48'h1, 0, 0, o);
`ifdef AMBER48_MEM_TIMEOUT_EN
    chk("tmo_done", 64'(o.done), 1);
    chk("tmo_trap_count", 64'(o.trap_seen), 1);
    chk("tmo_trap_cause", 64'(o.cause), 64'(TRAP_DATA_FAULT));
    chk("tmo_trap_cyc", 64'(o.trap_cyc), 64'(o.hs_cyc + 1 + int'(TMO)));
    chk("tmo_no_write", 64'(o.wr_seen), 0);
    rsp_valid = 1; rsp_data = 48'h4444;
    @(negedge clk);
    rsp_valid = 0; rsp_data = '0;
    @(negedge clk);
    chk("tmo_stray_ignored", {rf_req.valid, rf_req.we, trap, busy}, 0);
`else
    chk("nowait_still_busy", 64'(busy), 1);
    chk("nowait_no_trap", 64'(o.trap_seen), 0);
    chk("nowait_no_write", 64'(o.wr_seen), 0);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("nowait_idle_after_rst", 64'(in_ready), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
